isp_yuv444to422: RTL
====================

Name: isp_yuv444to422

Overview:
- Chroma subsampler placed directly after the Y gamma stage in the YUV path.
- Consumes 4:4:4 pixels and produces 4:2:2 pixels in the order Y0/U, Y1/V.
- U is the rounded average of the U values of a horizontal pixel pair; V likewise.
- Also checks the line length against WIDTH and flags lines that do not match.

Parameters:
- BITS, 8, component bit width for Y/U/V.
- WIDTH, 1280, expected active pixels per line; used for the length check only.
- HEIGHT, 960, expected lines per frame; used for the line counter wrap only.

Ports:
- pclk  input  1  pixel clock; every register updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- in_href  input  1  active-pixel qualifier; one pixel per cycle while high.
- in_vsync  input  1  frame sync, passed through.
- in_y  input  BITS  luma.
- in_u  input  BITS  Cb.
- in_v  input  BITS  Cr.
- out_href  output  1  in_href delayed by 2 cycles.
- out_vsync  output  1  in_vsync delayed by 2 cycles.
- out_y  output  BITS  luma delayed by 2 cycles; 0 when out_href=0.
- out_c  output  BITS  interleaved chroma (U on even pixels, V on odd pixels); 0 when out_href=0.
- out_line_err  output  1  one-cycle pulse when a line ends with a pixel count other than WIDTH.
- out_line_cnt  output  16  index of the line currently being received; 0-based, wraps at HEIGHT.

Behaviour:
- Reset, sampled at a pclk edge while rst=1:
  - All pipeline registers, phase, and pixel/line counters are cleared.
  - All outputs read 0 on the following cycle.
  - A reset in mid-line discards any pixel pair in flight.
  - After reset is released, the first href-high cycle is treated as pixel 0 (even).
- Phase bit:
  - Toggles on every cycle with in_href=1.
  - Forced to 0 on every cycle with in_href=0, so a pair never spans two lines.
- Stage 1 registers in_href, in_vsync, in_y, in_u, in_v and the phase.
- Stage 2, even pixel (phase 0), input at cycle t:
  - Hold its U and V.
  - If in_href=1 at t+1 (the partner pixel exists):
    - U_avg = (U_even + U_odd + 1) >> 1.
    - V_avg = (V_even + V_odd + 1) >> 1.
    - Both sums are BITS+1 wide; there is no overflow.
  - If in_href=0 at t+1 (odd-length line):
    - U_avg = U_even and V_avg = V_even.
- Output timing:
  - Even pixel from input cycle t appears at t+2 with out_y=Y_even and out_c=U_avg.
  - Odd pixel from t+1 appears at t+3 with out_y=Y_odd and out_c=V_avg.
  - out_href and out_vsync are in_href and in_vsync delayed by exactly 2 cycles, for a fixed latency of 2.
- Blanking: out_y and out_c are forced to 0 whenever out_href=0.
- Pixel counter:
  - Counts href-high cycles within a line and saturates at 16'hFFFF.
  - Cleared on the cycle after the href falling edge.
- Line-length error:
  - Evaluated on the input href falling edge: if count != WIDTH, out_line_err pulses high for one cycle.
  - The pulse is aligned with the first out_href=0 cycle, i.e. input fall + 2.
- Line counter:
  - Increments on each input href falling edge and wraps from HEIGHT-1 to 0.
  - Cleared on the in_vsync rising edge.
  - If the vsync rise and the href fall occur in the same cycle, the clear wins.
- vsync does not affect the pairing logic; only href gates it.
- Back-to-back lines (href low for exactly 1 cycle) are supported; the phase is 0 at the start of the next line.

Test Plan:
- Reset sequencing: hold rst=1 for 3 cycles with inputs toggling -> all outputs 0; after release, the first href pixel appears at +2.
- Single even-length line, WIDTH=4, Y=10,20,30,40, U=100,103,50,50, V=200,201,0,1:
  - out_y = 10,20,30,40 and out_c = 102,201,50,1, starting 2 cycles after the href rise.
  - out_line_err=0.
- Odd-length line, 3 pixels with WIDTH=4, U=7,9,60, V=8,8,90:
  - out_c = 8,8,60.
  - out_line_err pulses once, 2 cycles after the href fall.
- Extremes (rounding and no overflow), U pair 255,255 -> out_c 255; U pair 0,1 -> out_c 1.
- Line counting, with HEIGHT=2 and 3 lines separated by a 1-cycle href gap:
  - out_line_cnt goes 0,1,0.
  - The pairing phase restarts cleanly on each line.
  - A vsync rise in the same cycle as an href fall forces the count to 0.
- Mid-line reset: assert rst for 1 cycle after pixel 1 of 4 -> outputs 0 next cycle; the following line pairs correctly from pixel 0.

Source files
------------

// File: rtl/isp_yuv444to422.sv
// 4:4:4 to 4:2:2 chroma subsampler with a fixed two-cycle latency.
// Averages U/V over horizontal pixel pairs and monitors line length and line index.
module isp_yuv444to422 #(
  parameter int BITS   = 8,
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic [BITS-1:0] in_y,
  input  logic [BITS-1:0] in_u,
  input  logic [BITS-1:0] in_v,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_y,
  output logic [BITS-1:0] out_c,
  output logic            out_line_err,
  output logic [15:0]     out_line_cnt
);

  logic            phase_q, phase_d;
  logic            s1_href_q, s1_vsync_q, s1_phase_q;
  logic [BITS-1:0] s1_y_q, s1_u_q, s1_v_q;
  logic [BITS-1:0] v_hold_q, v_hold_d;
  logic [15:0]     pix_cnt_q, pix_cnt_d;
  logic [15:0]     line_cnt_q, line_cnt_d;
  logic            err_q, err_d;
  logic            out_href_q, out_vsync_q, out_err_q;
  logic [BITS-1:0] out_y_q, out_y_d, out_c_q, out_c_d;

  logic            href_fall_s, vsync_rise_s;
  logic [BITS:0]   u_sum_s, v_sum_s;
  logic [BITS-1:0] u_avg_s, v_avg_s;

  // Pairing, blanking and line bookkeeping; the odd partner is read straight off the input.
  always_comb begin
    phase_d      = in_href ? ~phase_q : 1'b0;
    href_fall_s  = s1_href_q & ~in_href;
    vsync_rise_s = in_vsync & ~s1_vsync_q;

    u_sum_s = {1'b0, s1_u_q} + {1'b0, in_u} + {{BITS{1'b0}}, 1'b1};
    v_sum_s = {1'b0, s1_v_q} + {1'b0, in_v} + {{BITS{1'b0}}, 1'b1};
    if (in_href) begin
      u_avg_s = u_sum_s[BITS:1];
      v_avg_s = v_sum_s[BITS:1];
    end else begin
      u_avg_s = s1_u_q;
      v_avg_s = s1_v_q;
    end

    if (s1_href_q && !s1_phase_q) begin
      v_hold_d = v_avg_s;
    end else begin
      v_hold_d = v_hold_q;
    end

    if (!s1_href_q) begin
      out_y_d = {BITS{1'b0}};
      out_c_d = {BITS{1'b0}};
    end else if (!s1_phase_q) begin
      out_y_d = s1_y_q;
      out_c_d = u_avg_s;
    end else begin
      out_y_d = s1_y_q;
      out_c_d = v_hold_q;
    end

    if (in_href) begin
      pix_cnt_d = (pix_cnt_q == 16'hFFFF) ? pix_cnt_q : pix_cnt_q + 16'd1;
    end else if (href_fall_s) begin
      pix_cnt_d = 16'd0;
    end else begin
      pix_cnt_d = pix_cnt_q;
    end

    err_d = href_fall_s && (pix_cnt_q != 16'(WIDTH));

    // A frame start overrides a simultaneous line end.
    if (vsync_rise_s) begin
      line_cnt_d = 16'd0;
    end else if (href_fall_s) begin
      line_cnt_d = (line_cnt_q == 16'(HEIGHT - 1)) ? 16'd0 : line_cnt_q + 16'd1;
    end else begin
      line_cnt_d = line_cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      phase_q     <= 1'b0;
      s1_href_q   <= 1'b0;
      s1_vsync_q  <= 1'b0;
      s1_phase_q  <= 1'b0;
      s1_y_q      <= {BITS{1'b0}};
      s1_u_q      <= {BITS{1'b0}};
      s1_v_q      <= {BITS{1'b0}};
      v_hold_q    <= {BITS{1'b0}};
      pix_cnt_q   <= 16'd0;
      line_cnt_q  <= 16'd0;
      err_q       <= 1'b0;
      out_href_q  <= 1'b0;
      out_vsync_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_y_q     <= {BITS{1'b0}};
      out_c_q     <= {BITS{1'b0}};
    end else begin
      phase_q     <= phase_d;
      s1_href_q   <= in_href;
      s1_vsync_q  <= in_vsync;
      s1_phase_q  <= phase_q;
      s1_y_q      <= in_y;
      s1_u_q      <= in_u;
      s1_v_q      <= in_v;
      v_hold_q    <= v_hold_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      err_q       <= err_d;
      out_href_q  <= s1_href_q;
      out_vsync_q <= s1_vsync_q;
      out_err_q   <= err_q;
      out_y_q     <= out_y_d;
      out_c_q     <= out_c_d;
    end
  end

  assign out_href     = out_href_q;
  assign out_vsync    = out_vsync_q;
  assign out_y        = out_y_q;
  assign out_c        = out_c_q;
  assign out_line_err = out_err_q;
  assign out_line_cnt = line_cnt_q;

endmodule
